sram_req_arbiter: RTL and testbench

- Shares one SRAM-like master port (req/addr_ok/data_ok protocol) between the instruction-fetch requester and the data (load/store) requester.
- Sits between the pipeline (fetch stage and memory stage) and the AXI bridge / unified memory.
- Arbitrates address phases and holds a granted request until it is accepted.
- Records the requester of every accepted request so in-order responses are routed back to the correct requester.

---
 rtl/sram_req_arbiter_if.sv | 23 ++
 rtl/sram_req_arbiter.sv | 127 ++++++++++++
 tb/tb_sram_req_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_req_arbiter_if.sv
// SRAM-like request port: address phase (req/addr_ok) followed by an
// in-order data phase (data_ok/rdata). "master" is the side issuing requests.
interface sram_req_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like master port between the fetch (inst) and memory-stage
// (data) requesters. Address phases are arbitrated with data priority, a
// stalled grant is locked until accepted, and an ID FIFO routes the in-order
// responses back to whichever requester issued them.
module sram_req_arbiter #(
    parameter int MAX_OUT = 2
) (
    input  logic               clk,
    input  logic               reset,
    sram_req_arbiter_if.slave  inst,
    sram_req_arbiter_if.slave  data,
    sram_req_arbiter_if.master m
);
    localparam int CW = $clog2(MAX_OUT) + 1;
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    typedef enum logic {SRC_INST = 1'b0, SRC_DATA = 1'b1} src_e;

    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    src_e          id_mem [MAX_OUT];
    src_e          head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    logic          lock_valid;
    src_e          lock_id;
    logic          grant_vld;
    src_e          grant_id;
    logic          m_req_int;

    // Pointers wrap at MAX_OUT rather than relying on natural overflow.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_full  = (count == CW'(MAX_OUT));
    assign fifo_empty = (count == '0);
    assign head       = id_mem[rd_ptr];

    // Grant selection: a held (locked) request always wins; otherwise data
    // beats inst. Nothing is granted while the ID FIFO has no free slot.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = SRC_INST;
        if (!reset && !fifo_full) begin
            if (lock_valid) begin
                grant_vld = 1'b1;
                grant_id  = lock_id;
            end else if (data.req) begin
                grant_vld = 1'b1;
                grant_id  = SRC_DATA;
            end else if (inst.req) begin
                grant_vld = 1'b1;
                grant_id  = SRC_INST;
            end
        end
    end

    // Forward the granted requester onto the master port; zeros when idle.
    always_comb begin
        m_req_int = 1'b0;
        m.wr      = 1'b0;
        m.size    = '0;
        m.wstrb   = '0;
        m.addr    = '0;
        m.wdata   = '0;
        if (grant_vld) begin
            if (grant_id == SRC_DATA) begin
                m_req_int = data.req;
                m.wr      = data.wr;
                m.size    = data.size;
                m.wstrb   = data.wstrb;
                m.addr    = data.addr;
                m.wdata   = data.wdata;
            end else begin
                m_req_int = inst.req;
                m.wr      = inst.wr;
                m.size    = inst.size;
                m.wstrb   = inst.wstrb;
                m.addr    = inst.addr;
                m.wdata   = inst.wdata;
            end
        end
    end

    assign m.req = m_req_int;
    assign push  = m_req_int && m.addr_ok;
    // A response with nothing outstanding is a protocol error and is dropped.
    assign pop   = m.data_ok && !fifo_empty && !reset;

    assign inst.addr_ok = push && (grant_id == SRC_INST);
    assign data.addr_ok = push && (grant_id == SRC_DATA);
    assign inst.data_ok = pop && (head == SRC_INST);
    assign data.data_ok = pop && (head == SRC_DATA);
    assign inst.rdata   = m.rdata;
    assign data.rdata   = m.rdata;

    // FIFO pointers/occupancy and the grant lock.
    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            lock_valid <= 1'b0;
            lock_id    <= SRC_INST;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
            if (m_req_int && !m.addr_ok) begin
                lock_valid <= 1'b1;
                lock_id    <= grant_id;
            end else if (m.addr_ok) begin
                lock_valid <= 1'b0;
            end
        end
    end

    // ID storage; contents are don't-care until written, reads are gated by count.
    always_ff @(posedge clk) begin
        if (push) id_mem[wr_ptr] <= grant_id;
    end
endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: directed scenarios followed by randomized
// traffic, every cycle compared against a queue-based reference model.
module tb_sram_req_arbiter;
    localparam int MAX_OUT = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sram_req_arbiter_if i_if ();
    sram_req_arbiter_if d_if ();
    sram_req_arbiter_if m_if ();

    sram_req_arbiter #(.MAX_OUT(MAX_OUT)) dut (
        .clk   (clk),
        .reset (reset),
        .inst  (i_if),
        .data  (d_if),
        .m     (m_if)
    );

    // Reference model: outstanding requester IDs in acceptance order, and the
    // requester currently holding the port (-1 when none).
    bit q[$];
    int owner = -1;
    int vectors = 0;
    int errors = 0;
    bit e_iok, e_dok, e_idok, e_ddok, e_mreq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        i_if.req = 0; i_if.wr = 0; i_if.size = 0; i_if.wstrb = 0; i_if.addr = 0; i_if.wdata = 0;
        d_if.req = 0; d_if.wr = 0; d_if.size = 0; d_if.wstrb = 0; d_if.addr = 0; d_if.wdata = 0;
        m_if.addr_ok = 0; m_if.data_ok = 0; m_if.rdata = 0;
    endtask

    // One clock: predict from current inputs, compare, clock, advance model.
    task automatic cycle();
        bit          gv, gid, full, dok;
        logic        ewr;
        logic [1:0]  esize;
        logic [3:0]  ewstrb;
        logic [31:0] eaddr, ewdata;
        full = (q.size() >= MAX_OUT);
        gv = 0; gid = 0;
        if (!reset && !full) begin
            if (owner >= 0)      begin gv = 1; gid = (owner == 1); end
            else if (d_if.req)   begin gv = 1; gid = 1; end
            else if (i_if.req)   begin gv = 1; gid = 0; end
        end
        e_mreq = gv && (gid ? d_if.req : i_if.req);
        ewr = 0; esize = 0; ewstrb = 0; eaddr = 0; ewdata = 0;
        if (gv) begin
            ewr    = gid ? d_if.wr    : i_if.wr;
            esize  = gid ? d_if.size  : i_if.size;
            ewstrb = gid ? d_if.wstrb : i_if.wstrb;
            eaddr  = gid ? d_if.addr  : i_if.addr;
            ewdata = gid ? d_if.wdata : i_if.wdata;
        end
        e_iok  = e_mreq && m_if.addr_ok && !gid;
        e_dok  = e_mreq && m_if.addr_ok && gid;
        dok    = m_if.data_ok && !reset && (q.size() > 0);
        e_idok = dok && (q[0] == 0);
        e_ddok = dok && (q[0] == 1);
        #3;
        chk("m_req",        m_if.req,     e_mreq);
        chk("m_wr",         m_if.wr,      ewr);
        chk("m_size",       m_if.size,    esize);
        chk("m_wstrb",      m_if.wstrb,   ewstrb);
        chk("m_addr",       m_if.addr,    eaddr);
        chk("m_wdata",      m_if.wdata,   ewdata);
        chk("inst_addr_ok", i_if.addr_ok, e_iok);
        chk("data_addr_ok", d_if.addr_ok, e_dok);
        chk("inst_data_ok", i_if.data_ok, e_idok);
        chk("data_data_ok", d_if.data_ok, e_ddok);
        chk("fifo_count",   dut.count,    q.size());
        if (!reset) begin
            chk("inst_rdata", i_if.rdata, m_if.rdata);
            chk("data_rdata", d_if.rdata, m_if.rdata);
        end
        @(posedge clk);
        if (reset) begin
            q.delete();
            owner = -1;
        end else begin
            if (dok) void'(q.pop_front());
            if (e_mreq && m_if.addr_ok) q.push_back(gid);
            if (e_mreq && !m_if.addr_ok) owner = gid;
            else if (m_if.addr_ok)       owner = -1;
        end
        #1;
    endtask

    bit i_pend, d_pend;

    initial begin
        idle();
        reset = 1;
        cycle();
        cycle();
        reset = 0;

        // Single fetch: accepted same cycle, answered two cycles later.
        i_if.req = 1; i_if.size = 2; i_if.wstrb = 4'hf; i_if.addr = 32'h1c000000;
        m_if.addr_ok = 1;
        cycle();
        chk("t1_iok", e_iok, 1'b1);
        idle();
        cycle();
        m_if.data_ok = 1; m_if.rdata = 32'h02800c0c;
        cycle();
        chk("t1_idok", e_idok, 1'b1);
        idle();
        cycle();
        chk("t1_count", dut.count, 0);

        // Simultaneous requests: data first, then inst; responses D then I.
        i_if.req = 1; i_if.addr = 32'h1c000004; i_if.size = 2; i_if.wstrb = 4'hf;
        d_if.req = 1; d_if.wr = 1; d_if.addr = 32'h1c001000; d_if.wstrb = 4'hf;
        d_if.size = 2; d_if.wdata = 32'hdeadbeef;
        m_if.addr_ok = 1;
        cycle();
        chk("t2_dok_first", e_dok, 1'b1);
        d_if.req = 0;
        cycle();
        chk("t2_iok_second", e_iok, 1'b1);
        idle();
        m_if.data_ok = 1; m_if.rdata = 32'h11111111;
        cycle();
        chk("t2_resp_d", e_ddok, 1'b1);
        m_if.rdata = 32'h22222222;
        cycle();
        chk("t2_resp_i", e_idok, 1'b1);
        idle();

        // Stalled inst grant stays locked even after data_req rises.
        i_if.req = 1; i_if.addr = 32'h1c000040; i_if.size = 2; i_if.wstrb = 4'hf;
        cycle();
        d_if.req = 1; d_if.addr = 32'h1c002000; d_if.wr = 1; d_if.wstrb = 4'h3; d_if.size = 1;
        cycle();
        chk("t3_hold1", m_if.addr, 32'h1c000040);
        cycle();
        chk("t3_hold2", m_if.addr, 32'h1c000040);
        m_if.addr_ok = 1;
        cycle();
        chk("t3_iok", e_iok, 1'b1);
        i_if.req = 0;
        cycle();
        chk("t3_dok", e_dok, 1'b1);
        d_if.req = 0; m_if.addr_ok = 0; m_if.data_ok = 1;
        cycle();
        cycle();
        idle();

        // Fill the ID FIFO, stall a third request, free a slot, accept it.
        i_if.req = 1; i_if.size = 2; i_if.wstrb = 4'hf; m_if.addr_ok = 1;
        i_if.addr = 32'h1c000100; cycle();
        i_if.addr = 32'h1c000104; cycle();
        i_if.addr = 32'h1c000108; cycle();
        chk("t4_full_block", m_if.req, 1'b0);
        m_if.data_ok = 1; m_if.rdata = 32'h0000aaaa;
        cycle();
        chk("t4_pop_while_full", e_idok, 1'b1);
        m_if.data_ok = 0;
        cycle();
        chk("t4_third_accept", e_iok, 1'b1);
        i_if.req = 0; m_if.addr_ok = 0; m_if.data_ok = 1;
        cycle();
        chk("t4_count1", dut.count, 1);

        // Push and pop together at count=1: response goes to the old head.
        m_if.data_ok = 1; m_if.addr_ok = 1;
        d_if.req = 1; d_if.addr = 32'h1c003000; d_if.size = 0; d_if.wstrb = 4'h1;
        cycle();
        chk("t5_old_head", e_idok, 1'b1);
        chk("t5_push", e_dok, 1'b1);
        idle();
        cycle();
        chk("t5_count", dut.count, 1);
        m_if.data_ok = 1;
        cycle();
        chk("t5_new_head", e_ddok, 1'b1);
        idle();

        // Reset with two outstanding, then a stray response afterwards.
        i_if.req = 1; i_if.addr = 32'h1c000200; i_if.size = 2; m_if.addr_ok = 1;
        cycle();
        cycle();
        reset = 1; d_if.req = 1; m_if.data_ok = 1;
        cycle();
        chk("t6_rst_mreq", m_if.req, 1'b0);
        chk("t6_rst_iok", i_if.data_ok, 1'b0);
        reset = 0;
        idle();
        m_if.data_ok = 1;
        cycle();
        chk("t6_stray_dropped", i_if.data_ok | d_if.data_ok, 1'b0);
        idle();

        // Randomized traffic; requesters hold until accepted.
        i_pend = 0; d_pend = 0;
        for (int n = 0; n < 600; n++) begin
            if (!i_pend && $urandom_range(0, 2) != 0) begin
                i_pend = 1; i_if.wr = 0;
                i_if.size = 2'($urandom_range(0, 2)); i_if.wstrb = 4'($urandom);
                i_if.addr = $urandom; i_if.wdata = $urandom;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1; d_if.wr = 1'($urandom);
                d_if.size = 2'($urandom_range(0, 2)); d_if.wstrb = 4'($urandom);
                d_if.addr = $urandom; d_if.wdata = $urandom;
            end
            i_if.req = i_pend;
            d_if.req = d_pend;
            m_if.addr_ok = ($urandom_range(0, 9) < 6);
            m_if.data_ok = (q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
            m_if.rdata = $urandom;
            reset = ($urandom_range(0, 99) == 0);
            cycle();
            if (reset) begin
                i_pend = 0; d_pend = 0;
            end else begin
                if (e_iok) i_pend = 0;
                if (e_dok) d_pend = 0;
            end
        end
        reset = 0;
        idle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
